ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending side that pairs with the existing receive-only `ps2_keyb` block. Used to send keyboard commands such as LED set, typematic rate and reset. A Wishbone slave write of one byte at I/O port 0x60 starts a full host-request-to-send sequence: clock inhibit, start bit, 8 data bits, odd parity, stop, then device acknowledge. Sits on the CPU I/O bus beside the keyboard receiver and shares the open-drain `ps2_clk_`/`ps2_data_` pads with it.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_edge_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_NACK = 1;
    localparam int STAT_TMO  = 2;
    localparam int STAT_OVR  = 3;

    // Data bits plus parity shifted out after the start bit
    localparam int FRAME_BITS = 9;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - Wishbone slave signal bundle for the PS/2 host transmitter
interface ps2_host_tx_if;

    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we_i;
    logic       wb_stb_i;
    logic       wb_cyc_i;
    logic       wb_ack_o;
    logic       wb_tgc_o;

    modport slave (
        input  wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_tgc_o
    );

    modport master (
        output wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_tgc_o
    );

endinterface

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - 2-flop pad synchronizer with falling-edge detect
module ps2_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad_i,
    output logic level_o,
    output logic fall_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Next values of the synchronizer chain and the edge-history flop
    always_comb begin
        s1_d   = pad_i;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Pads idle high, so the chain resets to 1 to avoid a phantom edge
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = s2_q;
    assign fall_o  = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter, optional watchdog under PS2_TX_TIMEOUT_EN
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 1250,
    parameter int INHIBIT_BITS   = 11,
    parameter int TIMEOUT_CYCLES = 187500,
    parameter int TIMEOUT_BITS   = 18
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    ps2_host_tx_if.slave  wb,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe_o,
    output logic          ps2_data_oe_o,
    output logic          rx_inhibit_o
);

    ps2_state_t              state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [INHIBIT_BITS-1:0] inh_cnt_q, inh_cnt_d;
    logic                    clk_oe_q, clk_oe_d;
    logic                    data_oe_q, data_oe_d;
    logic                    nack_q, nack_d;
    logic                    ovr_q, ovr_d;
    logic                    ack_q, ack_d;
    logic                    tgc_q, tgc_d;
    logic                    tmo_bit;
    logic                    busy;
    logic                    wr_accept;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

`ifdef PS2_TX_TIMEOUT_EN
    logic                    tmo_q, tmo_d;
    logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
    assign tmo_bit = tmo_q;
`else
    logic [TIMEOUT_BITS-1:0] tmo_limit_unused;
    assign tmo_limit_unused = TIMEOUT_BITS'(TIMEOUT_CYCLES);
    assign tmo_bit = 1'b0;
`endif

    ps2_edge_sync u_clk_sync (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .pad_i   (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_edge_sync u_data_sync (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .pad_i   (ps2_data_i),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    assign busy = (state_q != ST_IDLE);

    // Frame sequencing, bus handshake and status updates
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        ovr_d     = ovr_q;
        tgc_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        tmo_d     = tmo_q;
        wdog_d    = wdog_q;
`endif
        // Ack one cycle after the strobe; never on back-to-back cycles
        ack_d     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
        wr_accept = ack_d & wb.wb_we_i;

        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    shift_d   = {odd_parity(wb.wb_dat_i), wb.wb_dat_i};
                    nack_d    = 1'b0;
                    ovr_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    tmo_d     = 1'b0;
`endif
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INHIBIT_BITS'(INHIBIT_CYCLES - 1)) begin
                    state_d = ST_START;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_START: begin
                data_oe_d = 1'b1;
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                state_d   = ST_BITS;
            end
            ST_BITS: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    nack_d  = data_level;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    tgc_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A write landing while a frame is in flight is dropped and flagged
        if (wr_accept && busy) begin
            ovr_d = 1'b1;
        end

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog runs once the device owns the clock; any edge re-arms it
        if (state_q == ST_IDLE || state_q == ST_INHIBIT || clk_fall) begin
            wdog_d = '0;
        end else if (wdog_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)) begin
            wdog_d    = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            tmo_d     = 1'b1;
            tgc_d     = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
`endif
    end

    // State and output registers; reset releases both pads immediately
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ack_q     <= 1'b0;
            tgc_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_q     <= 1'b0;
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            nack_q    <= nack_d;
            ovr_q     <= ovr_d;
            ack_q     <= ack_d;
            tgc_q     <= tgc_d;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_q     <= tmo_d;
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign wb.wb_dat_o   = {4'b0000, ovr_q, tmo_bit, nack_q, busy};
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_tgc_o   = tgc_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign rx_inhibit_o  = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 1500;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       dev_ack;
        logic [7:0] exp_stat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_oe, data_oe, rx_inh;
    logic pad_clk, pad_data;

    int tests = 0;
    int fails = 0;
    int tgc_cnt = 0;
    int oe_run = 0;
    int oe_last = 0;

    always #5 clk = ~clk;

    assign pad_clk  = dev_clk & ~clk_oe;
    assign pad_data = dev_data & ~data_oe;

    ps2_host_tx_if wb_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .INHIBIT_BITS   (6),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_BITS   (11)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wb            (wb_if),
        .ps2_clk_i     (pad_clk),
        .ps2_data_i    (pad_data),
        .ps2_clk_oe_o  (clk_oe),
        .ps2_data_oe_o (data_oe),
        .rx_inhibit_o  (rx_inh)
    );

    always @(negedge clk) begin
        if (wb_if.wb_tgc_o) tgc_cnt <= tgc_cnt + 1;
        if (clk_oe) begin
            oe_run <= oe_run + 1;
        end else begin
            if (oe_run != 0) oe_last <= oe_run;
            oe_run <= 0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [7:0] d,
                            output logic [7:0] rd, output int lat, output logic oe_at_ack);
        @(negedge clk);
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_dat_i = d;
        lat = 0;
        rd = 8'h00;
        oe_at_ack = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (wb_if.wb_ack_o) begin
                lat = i;
                rd = wb_if.wb_dat_o;
                oe_at_ack = clk_oe;
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
            check("ack_single_cycle", int'(wb_if.wb_ack_o), 0);
        end
        @(negedge clk);
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
    endtask

    task automatic dev_frame(input int nedges, input logic ack_bit,
                             output logic [10:0] frame, output logic ok);
        frame = '1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (10) @(posedge clk);
            #1;
            frame[0] = pad_data;
            for (int e = 1; e <= nedges; e++) begin
                if (e == 11) dev_data = ack_bit ? 1'b0 : 1'b1;
                dev_clk = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                dev_clk = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                if (e <= 10) frame[e] = pad_data;
                if (e == 11) dev_data = 1'b1;
                repeat (15) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!rx_inh) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0]  rd;
        int          lat;
        logic        oe;
        logic [10:0] frame;
        logic [10:0] exp_frame;
        logic        ok;
        int          base;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{8'hA5, 1'b1, 1'b0, 8'h02};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 8'h00};

        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_dat_i = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_status", int'(wb_if.wb_dat_o), 0);
        check("rst_clk_oe", int'(clk_oe), 0);
        check("rst_data_oe", int'(data_oe), 0);
        check("rst_ack", int'(wb_if.wb_ack_o), 0);
        check("rst_tgc", int'(wb_if.wb_tgc_o), 0);
        check("rst_rx_inhibit", int'(rx_inh), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            base = tgc_cnt;
            wb_cycle(1'b1, vecs[i].data, rd, lat, oe);
            check("wr_ack_latency", lat, 1);
            check("wr_clk_oe_latency", int'(oe), 1);
            wb_cycle(1'b0, 8'h00, rd, lat, oe);
            check("busy_status", int'(rd), 8'h01);
            dev_frame(11, vecs[i].dev_ack, frame, ok);
            check("clk_released", int'(ok), 1);
            exp_frame = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
            check("frame_bits", int'(frame), int'(exp_frame));
            wait_done(ok);
            check("done_reached", int'(ok), 1);
            wb_cycle(1'b0, 8'h00, rd, lat, oe);
            check("done_status", int'(rd), int'(vecs[i].exp_stat));
            check("tgc_pulses", tgc_cnt - base, 1);
            if (i == 0) check("inhibit_len", int'(oe_last >= INH && oe_last <= INH + 1), 1);
        end

        // Second write during the inhibit window is dropped and flagged
        base = tgc_cnt;
        wb_cycle(1'b1, 8'h12, rd, lat, oe);
        wb_cycle(1'b1, 8'h34, rd, lat, oe);
        check("ovr_ack_latency", lat, 1);
        wb_cycle(1'b0, 8'h00, rd, lat, oe);
        check("ovr_status", int'(rd), 8'h09);
        dev_frame(11, 1'b1, frame, ok);
        exp_frame = {1'b1, 1'b1, 8'h12, 1'b0};
        check("ovr_frame_first_byte", int'(frame), int'(exp_frame));
        wait_done(ok);
        wb_cycle(1'b0, 8'h00, rd, lat, oe);
        check("ovr_done_status", int'(rd), 8'h08);
        check("ovr_tgc_pulses", tgc_cnt - base, 1);

        // Device stops clocking after four bits
        base = tgc_cnt;
        wb_cycle(1'b1, 8'h52, rd, lat, oe);
        wb_cycle(1'b0, 8'h00, rd, lat, oe);
        check("ovr_cleared_status", int'(rd), 8'h01);
        dev_frame(4, 1'b1, frame, ok);
        repeat (TMO + 200) @(posedge clk);
        wb_cycle(1'b0, 8'h00, rd, lat, oe);
`ifdef PS2_TX_TIMEOUT_EN
        check("tmo_status", int'(rd), 8'h04);
        check("tmo_clk_oe", int'(clk_oe), 0);
        check("tmo_data_oe", int'(data_oe), 0);
        check("tmo_tgc_pulses", tgc_cnt - base, 1);
`else
        check("stall_status", int'(rd), 8'h01);
        check("stall_rx_inhibit", int'(rx_inh), 1);
        check("stall_data_oe", int'(data_oe), 1);
        check("stall_no_tgc", tgc_cnt - base, 0);
`endif

        // One-cycle reset while the frame is stuck mid-bits
        base = tgc_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_clk_oe", int'(clk_oe), 0);
        check("midrst_data_oe", int'(data_oe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_cycle(1'b0, 8'h00, rd, lat, oe);
        check("midrst_status", int'(rd), 8'h00);
        repeat (50) @(negedge clk);
        check("midrst_no_tgc", tgc_cnt - base, 0);
        check("midrst_rx_inhibit", int'(rx_inh), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
